sdpram_fifo: RTL and testbench



---
 rtl/sdpram_fifo_pkg.sv | 11 +
 rtl/sdpram_fifo_ram.sv | 75 +++++++
 rtl/sdpram_fifo.sv | 102 ++++++++++
 tb/tb_sdpram_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_fifo_pkg.sv
// Shared configuration constants for the sdpram_fifo storage array.
package sdpram_fifo_pkg;

    // Both RAM ports run from the FIFO clock.
    localparam RAM_CLOCKING_MODE = "common_clock";

    // A read colliding with a write returns the old contents; the FIFO never
    // reads the slot it is writing, so it does not depend on either behaviour.
    localparam RAM_WRITE_MODE = "read_first";

endpackage : sdpram_fifo_pkg

// File: rtl/sdpram_fifo_ram.sv
// Simple dual-port RAM: port A writes with per-byte enables, port B reads into
// a resettable output register with one cycle of latency.
module SimpleDualPortRAM #(
    parameter              CLOCKING_MODE    = "common_clock",
    parameter              WRITE_MODE       = "read_first",
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BYTE_WRITE_WIDTH = 32,
    localparam int unsigned NUM_BYTES       = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
    input  logic                  clk_a,
    input  logic                  en_a_i,
    input  logic [NUM_BYTES-1:0]  we_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic                  clk_b,
    input  logic                  rstb_n,
    input  logic                  en_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o
);

    localparam int unsigned WORDS       = 1 << ADDR_WIDTH;
    localparam bit          WRITE_FIRST = (WRITE_MODE == "write_first");

    logic                  rd_clk;
    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // In common-clock mode the read port follows the write clock.
    assign rd_clk = (CLOCKING_MODE == "common_clock") ? clk_a : clk_b;

    // Byte-enabled write into the storage array.
    // NOTE: the array has no reset; clearing every word would prevent RAM
    // inference, and readers never consume a slot before it is written.
    always_ff @(posedge clk_a) begin
        if (en_a_i) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (we_a_i[b]) begin
                    mem_q[addr_a_i][b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
                        data_a_i[b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    // Select the word the read register captures, with optional write-first forwarding.
    // NOTE: rd_data_d gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_data_d = mem_q[addr_b_i];
        if (WRITE_FIRST && en_a_i && (addr_a_i == addr_b_i)) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (we_a_i[b]) begin
                    rd_data_d[b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
                        data_a_i[b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    // Read output register: loads on en_b_i, otherwise holds its word.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge rd_clk or negedge rstb_n) begin
        if (!rstb_n) begin
            rd_data_q <= '0;
        end else if (en_b_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign data_b_o = rd_data_q;

endmodule : SimpleDualPortRAM

// File: rtl/sdpram_fifo.sv
// First-word-fall-through FIFO over a 1-cycle-latency dual-port RAM. The RAM
// output register doubles as the head slot; a read is issued whenever that
// slot is empty or being popped, so the pop side sustains one word per cycle.
module sdpram_fifo
    import sdpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DATA_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_d,  wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d,  rd_ptr_q;
    logic [ADDR_WIDTH:0]   unread_d,  unread_q;
    logic [ADDR_WIDTH:0]   count_d,   count_q;
    logic                  head_valid_d, head_valid_q;

    logic push_fire;
    logic pop_fire;
    logic ren;

    // The head slot is included in count_q, so a full FIFO never overwrites
    // the word still sitting in the RAM output register.
    assign push_ready_o = (count_q != FULL_COUNT) && !flush_i;
    assign pop_valid_o  = head_valid_q;
    assign count_o      = count_q;

    assign push_fire = push_valid_i && push_ready_o;
    assign pop_fire  = head_valid_q && pop_ready_i && !flush_i;
    assign ren       = (unread_q != '0) && (!head_valid_q || pop_fire) && !flush_i;

    // Next-state for pointers, occupancy counters and the head flag.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(push_fire);
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(ren);
        unread_d     = unread_q + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(ren);
        count_d      = count_q  + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(pop_fire);
        head_valid_d = head_valid_q;
        if (ren) begin
            head_valid_d = 1'b1;
        end else if (pop_fire) begin
            head_valid_d = 1'b0;
        end
        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            unread_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            unread_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            unread_q     <= unread_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
        end
    end

    SimpleDualPortRAM #(
        .CLOCKING_MODE    (RAM_CLOCKING_MODE),
        .WRITE_MODE       (RAM_WRITE_MODE),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .DATA_WIDTH       (DATA_WIDTH),
        .BYTE_WRITE_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_a    (clk),
        .en_a_i   (push_fire),
        .we_a_i   (push_fire),
        .addr_a_i (wr_ptr_q),
        .data_a_i (push_data_i),
        .clk_b    (clk),
        .rstb_n   (rst_n),
        .en_b_i   (ren),
        .addr_b_i (rd_ptr_q),
        .data_b_o (pop_data_o)
    );

endmodule : sdpram_fifo

// File: tb/tb_sdpram_fifo.sv
// Self-checking bench for sdpram_fifo (DEPTH=4). The reference model is a
// queue of pushed words with their push cycles; the head becomes visible no
// earlier than two cycles after its push and one cycle after the prior pop.
module tb_sdpram_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          push_valid_i;
    logic          push_ready_o;
    logic [DW-1:0] push_data_i;
    logic          pop_valid_o;
    logic          pop_ready_i;
    logic [DW-1:0] pop_data_o;
    logic [AW:0]   count_o;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_data[$];
    int            m_time[$];
    logic [DW-1:0] popped[$];
    int            cyc       = 0;
    int            last_pop  = -10;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    sdpram_fifo #(
        .DATA_DEPTH (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_data_i  (push_data_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_data_o   (pop_data_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_data.delete();
        m_time.delete();
        last_pop  = -10;
        prev_hold = 1'b0;
    endtask

    // One clock cycle: compare outputs at the falling edge, update the model at the rising edge.
    task automatic tick();
        logic exp_ready, exp_valid, push_f, pop_f;
        @(negedge clk);
        exp_ready = (m_data.size() != DEPTH) && !flush_i;
        exp_valid = (m_data.size() > 0) && (cyc >= m_time[0] + 2) && (cyc >= last_pop + 1);
        n_vec++;
        if (push_ready_o !== exp_ready) begin
            n_err++;
            $display("FAIL push_ready cyc=%0d got=%b exp=%b", cyc, push_ready_o, exp_ready);
        end
        n_vec++;
        if (pop_valid_o !== exp_valid) begin
            n_err++;
            $display("FAIL pop_valid cyc=%0d got=%b exp=%b", cyc, pop_valid_o, exp_valid);
        end
        n_vec++;
        if (count_o !== (AW+1)'(m_data.size())) begin
            n_err++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count_o, m_data.size());
        end
        if (exp_valid) begin
            n_vec++;
            if (pop_data_o !== m_data[0]) begin
                n_err++;
                $display("FAIL pop_data cyc=%0d got=%h exp=%h", cyc, pop_data_o, m_data[0]);
            end
            if (prev_hold) begin
                n_vec++;
                if (pop_data_o !== prev_data) begin
                    n_err++;
                    $display("FAIL hold_stable cyc=%0d got=%h exp=%h", cyc, pop_data_o, prev_data);
                end
            end
        end
        push_f    = push_valid_i && exp_ready;
        pop_f     = exp_valid && pop_ready_i && !flush_i;
        prev_hold = exp_valid && !pop_ready_i && !flush_i;
        prev_data = pop_data_o;
        @(posedge clk);
        if (flush_i) begin
            model_clear();
        end else begin
            if (pop_f) begin
                popped.push_back(m_data.pop_front());
                void'(m_time.pop_front());
                last_pop = cyc;
            end
            if (push_f) begin
                m_data.push_back(push_data_i);
                m_time.push_back(cyc);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b1;
        repeat (DEPTH + 4) tick();
        pop_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_vec++;
        if (push_ready_o !== 1'b1 || pop_valid_o !== 1'b0 || count_o !== '0 || pop_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_values ready=%b valid=%b count=%0d data=%h exp 1/0/0/0",
                     push_ready_o, pop_valid_o, count_o, pop_data_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        push_valid_i = 1'b1;
        push_data_i  = 32'hA5;
        tick();
        push_valid_i = 1'b0;
        repeat (12) tick();
        n_vec++;
        if (pop_valid_o !== 1'b1 || pop_data_o !== 32'hA5 || count_o !== 1) begin
            n_err++;
            $display("FAIL single_hold valid=%b data=%h count=%0d exp 1/a5/1",
                     pop_valid_o, pop_data_o, count_o);
        end
        drain();
    endtask

    task automatic test_fill();
        popped.delete();
        for (int v = 1; v <= 5; v++) begin
            push_valid_i = 1'b1;
            push_data_i  = v;
            tick();
        end
        push_valid_i = 1'b0;
        n_vec++;
        if (push_ready_o !== 1'b0 || count_o !== DEPTH) begin
            n_err++;
            $display("FAIL fill_full ready=%b count=%0d exp 0/%0d", push_ready_o, count_o, DEPTH);
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (popped.size() != 4 || popped[i] !== DW'(i + 1)) begin
                n_err++;
                $display("FAIL fill_order idx=%0d got=%h exp=%h", i, popped[i], i + 1);
            end
        end
    endtask

    task automatic test_stream();
        popped.delete();
        pop_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push_valid_i = 1'b1;
            push_data_i  = i;
            tick();
            n_vec++;
            if (count_o > 2) begin
                n_err++;
                $display("FAIL stream_count i=%0d got=%0d exp<=2", i, count_o);
            end
        end
        drain();
        for (int i = 0; i < 100; i++) begin
            n_vec++;
            if (popped[i] !== DW'(i)) begin
                n_err++;
                $display("FAIL stream_order idx=%0d got=%h exp=%h", i, popped[i], i);
            end
        end
    endtask

    task automatic test_full_wrap();
        popped.delete();
        for (int v = 1; v <= 4; v++) begin
            push_valid_i = 1'b1;
            push_data_i  = v;
            tick();
        end
        push_valid_i = 1'b0;
        repeat (2) tick();
        push_valid_i = 1'b1;
        push_data_i  = 9;
        pop_ready_i  = 1'b1;
        tick();
        pop_ready_i  = 1'b0;
        tick();
        push_valid_i = 1'b0;
        n_vec++;
        if (count_o !== DEPTH) begin
            n_err++;
            $display("FAIL full_swap_count got=%0d exp=%0d", count_o, DEPTH);
        end
        drain();
        n_vec++;
        if (popped.size() != 5 || popped[4] !== 9) begin
            n_err++;
            $display("FAIL full_swap_order size=%0d last=%h exp 5/9", popped.size(), popped[4]);
        end
        repeat (3) begin
            for (int k = 0; k < DEPTH; k++) begin
                push_valid_i = 1'b1;
                push_data_i  = $urandom;
                tick();
            end
            drain();
        end
    endtask

    task automatic test_random();
        int pct[3] = '{30, 70, 100};
        for (int p = 0; p < 3; p++) begin
            repeat (3300) begin
                push_valid_i = ($urandom_range(99) < pct[p]);
                pop_ready_i  = ($urandom_range(99) < pct[p]);
                push_data_i  = $urandom;
                tick();
            end
            drain();
        end
    endtask

    task automatic test_flush();
        for (int v = 0; v < 3; v++) begin
            push_valid_i = 1'b1;
            push_data_i  = 32'h100 + v;
            tick();
        end
        push_valid_i = 1'b0;
        repeat (2) tick();
        flush_i      = 1'b1;
        push_valid_i = 1'b1;
        push_data_i  = 32'hDEAD;
        tick();
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        n_vec++;
        if (count_o !== '0 || pop_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear count=%0d valid=%b exp 0/0", count_o, pop_valid_o);
        end
        push_valid_i = 1'b1;
        push_data_i  = 32'h77;
        tick();
        push_valid_i = 1'b0;
        tick();
        n_vec++;
        if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h77) begin
            n_err++;
            $display("FAIL flush_repush valid=%b data=%h exp 1/77", pop_valid_o, pop_data_o);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        repeat (20) begin
            push_valid_i = ($urandom_range(99) < 70);
            pop_ready_i  = ($urandom_range(99) < 30);
            push_data_i  = $urandom;
            tick();
        end
        rst_n        = 1'b0;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        #1;
        n_vec++;
        if (push_ready_o !== 1'b1 || pop_valid_o !== 1'b0 || count_o !== '0 || pop_data_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset ready=%b valid=%b count=%0d data=%h exp 1/0/0/0",
                     push_ready_o, pop_valid_o, count_o, pop_data_o);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) begin
            push_valid_i = ($urandom_range(99) < 50);
            pop_ready_i  = ($urandom_range(99) < 50);
            push_data_i  = $urandom;
            tick();
        end
        drain();
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        push_data_i  = '0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_full_wrap();
        test_random();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sdpram_fifo
